// File: rtl/line_follow_cntrl.sv
// Line-follower motion controller: sweeps IR pairs through the shared A2D, forms a
// position-weighted steering error and closes a saturating PI loop onto the motors.
module line_follow_cntrl #(
  parameter int NUM_PAIRS = 3,
  parameter int RES_W     = 12,
  parameter int MTR_W     = 11,
  parameter int SETTLE    = 4096,
  parameter int KP        = 8,
  parameter int KI        = 0,
  parameter int FWD_SPD   = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  output logic                    start_conv,
  output logic [2:0]              chnnl,
  input  logic                    cnv_cmplt,
  input  logic [RES_W-1:0]        A2D_res,
  output logic [NUM_PAIRS-1:0]    IR_en,
  output logic [7:0]              LEDs,
  output logic signed [MTR_W-1:0] lft,
  output logic signed [MTR_W-1:0] rht
);

  localparam int ACC_W = RES_W + NUM_PAIRS + 1;
  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam int M_MAX = 2**(MTR_W-1) - 1;
  localparam int M_MIN = -(2**(MTR_W-1));
  localparam logic signed [ACC_W-1:0] E_MAX = ACC_W'(2047);
  localparam logic signed [ACC_W-1:0] E_MIN = ACC_W'(-2048);
  localparam logic signed [11:0] ERR_MAX = 12'h7FF;
  localparam logic signed [11:0] ERR_MIN = 12'h800;
  localparam logic signed [16:0] I_MAX = 17'sh07FFF;
  localparam logic signed [16:0] I_MIN = 17'sh18000;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CONV_R, S_WAIT_R, S_CONV_L, S_WAIT_L, S_NEXT, S_CALC
  } state_t;

  state_t state, nxt;

  logic [CNT_W-1:0]        cnt;
  logic [1:0]              pair;
  logic [RES_W-1:0]        r_val, l_val;
  logic signed [ACC_W-1:0] acc, r_ext, l_ext, diff;
  logic signed [15:0]      integ, integ_nxt;
  logic signed [16:0]      integ_sum;
  logic signed [11:0]      err_sat;
  logic signed [31:0]      p_term, i_term;
  logic signed [MTR_W-1:0] corr, lft_nxt, rht_nxt;
  logic                    abort, last_pair, settled;

  function automatic logic signed [MTR_W-1:0] sat_mtr(input logic signed [31:0] v);
    if (v > M_MAX)      return MTR_W'(M_MAX);
    else if (v < M_MIN) return MTR_W'(M_MIN);
    else                return MTR_W'(v);
  endfunction

  assign abort     = !go && (state != S_IDLE) && (state != S_CALC);
  assign last_pair = (pair == 2'(NUM_PAIRS-1));
  assign settled   = (cnt == CNT_W'(SETTLE-1));

  assign start_conv = (state == S_CONV_R) || (state == S_CONV_L);
  assign chnnl = (state inside {S_CONV_R, S_WAIT_R, S_CONV_L, S_WAIT_L}) ?
                 {pair, (state == S_CONV_L) || (state == S_WAIT_L)} : 3'd0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    if (abort) nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:   if (go) nxt = S_SETTLE;
        S_SETTLE: if (settled) nxt = S_CONV_R;
        S_CONV_R: nxt = S_WAIT_R;
        S_WAIT_R: if (cnv_cmplt) nxt = S_CONV_L;
        S_CONV_L: nxt = S_WAIT_L;
        S_WAIT_L: if (cnv_cmplt) nxt = S_NEXT;
        S_NEXT:   nxt = last_pair ? S_CALC : S_SETTLE;
        S_CALC:   nxt = go ? S_SETTLE : S_IDLE;
        default:  nxt = S_IDLE;
      endcase
    end
  end

  // Raw readings are unsigned; widen with zeros before the signed difference.
  assign r_ext = $signed({{(ACC_W-RES_W){1'b0}}, r_val});
  assign l_ext = $signed({{(ACC_W-RES_W){1'b0}}, l_val});
  assign diff  = r_ext - l_ext;

  always_comb begin
    if (acc > E_MAX)      err_sat = ERR_MAX;
    else if (acc < E_MIN) err_sat = ERR_MIN;
    else                  err_sat = acc[11:0];
    integ_sum = {integ[15], integ} + {{5{err_sat[11]}}, err_sat};
    if (integ_sum > I_MAX)      integ_nxt = 16'sh7FFF;
    else if (integ_sum < I_MIN) integ_nxt = 16'sh8000;
    else                        integ_nxt = integ_sum[15:0];
    // The I term uses the integrator value being written this CALC.
    p_term  = (32'(err_sat) * KP) >>> 3;
    i_term  = (32'(integ_nxt) * KI) >>> 8;
    corr    = sat_mtr(p_term + i_term);
    lft_nxt = sat_mtr(FWD_SPD - 32'(corr));
    rht_nxt = sat_mtr(FWD_SPD + 32'(corr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      pair  <= '0;
      r_val <= '0;
      l_val <= '0;
      acc   <= '0;
      integ <= '0;
      IR_en <= '0;
      LEDs  <= '0;
      lft   <= '0;
      rht   <= '0;
    end else if (abort) begin
      cnt   <= '0;
      IR_en <= '0;
      integ <= '0;
      lft   <= '0;
      rht   <= '0;
    end else begin
      case (state)
        S_IDLE: if (go) begin
          pair  <= '0;
          IR_en <= NUM_PAIRS'(1);
          acc   <= '0;
          cnt   <= '0;
        end
        S_SETTLE: cnt <= settled ? '0 : cnt + 1'b1;
        S_WAIT_R: if (cnv_cmplt) r_val <= A2D_res;
        S_WAIT_L: if (cnv_cmplt) l_val <= A2D_res;
        S_NEXT: begin
          acc <= acc + (diff <<< pair);
          if (last_pair) IR_en <= '0;
          else begin
            pair  <= pair + 2'd1;
            IR_en <= IR_en << 1;
          end
        end
        S_CALC: begin
          integ <= integ_nxt;
          lft   <= lft_nxt;
          rht   <= rht_nxt;
          LEDs  <= err_sat[11:4];
          if (go) begin
            pair  <= '0;
            IR_en <= NUM_PAIRS'(1);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_follow_cntrl.sv
// Scoreboard bench for line_follow_cntrl: KI=0 and KI=8 instances share one A2D model.
module tb_line_follow_cntrl;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go = 1'b0;
  logic cnv_cmplt = 1'b0;
  logic [11:0] A2D_res = '0;
  logic start_conv, start_conv_i;
  logic [2:0] chnnl, chnnl_i, IR_en, IR_en_i;
  logic [7:0] LEDs, LEDs_i;
  logic signed [10:0] lft, rht, lft_i, rht_i;

  always #5 clk = ~clk;

  line_follow_cntrl #(.NUM_PAIRS(3), .RES_W(12), .MTR_W(11), .SETTLE(8), .KP(8), .KI(0),
                      .FWD_SPD(512)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .start_conv(start_conv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res), .IR_en(IR_en), .LEDs(LEDs),
    .lft(lft), .rht(rht));

  line_follow_cntrl #(.NUM_PAIRS(3), .RES_W(12), .MTR_W(11), .SETTLE(8), .KP(8), .KI(8),
                      .FWD_SPD(512)) dut_i (
    .clk(clk), .rst_n(rst_n), .go(go), .start_conv(start_conv_i), .chnnl(chnnl_i),
    .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res), .IR_en(IR_en_i), .LEDs(LEDs_i),
    .lft(lft_i), .rht(rht_i));

  typedef struct {int l; int r; int leds; int li; int ri;} exp_t;
  exp_t sb[$];
  int   conv_q[$];
  int   chv[6];
  int   integ_i;
  int   oh_bad;
  int   n_run, n_fail;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic void set_ch(input int c0, input int c1, input int c4, input int c5);
    chv = '{c0, c1, 354, 354, c4, c5};
  endfunction

  // Reference computed straight from the control law; integ_i tracks the KI=8 instance.
  task automatic push_exp();
    int acc, e, p, corr, corr_i;
    exp_t x;
    acc = 0;
    for (int k = 0; k < 3; k++) acc += (chv[2*k] - chv[2*k+1]) * (1 << k);
    e       = clamp(acc, -2048, 2047);
    integ_i = clamp(integ_i + e, -32768, 32767);
    p       = (e * 8) >>> 3;
    corr    = clamp(p, -1024, 1023);
    corr_i  = clamp(p + ((integ_i * 8) >>> 8), -1024, 1023);
    x.l     = clamp(512 - corr, -1024, 1023);
    x.r     = clamp(512 + corr, -1024, 1023);
    x.li    = clamp(512 - corr_i, -1024, 1023);
    x.ri    = clamp(512 + corr_i, -1024, 1023);
    x.leds  = (e >>> 4) & 8'hFF;
    sb.push_back(x);
  endtask

  // A2D model: answers each start_conv LAT cycles later; also logs channels and IR_en.
  initial begin
    int pend, pend_ch;
    pend = 0;
    pend_ch = 0;
    forever begin
      @(posedge clk);
      #1;
      cnv_cmplt = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          cnv_cmplt = 1'b1;
          A2D_res   = 12'(chv[pend_ch]);
        end
      end
      if (start_conv) begin
        pend    = LAT;
        pend_ch = int'(chnnl);
        conv_q.push_back(int'(chnnl));
      end
      if (!$onehot0(IR_en) || !$onehot0(IR_en_i)) oh_bad++;
    end
  end

  task automatic do_reset();
    go = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    integ_i = 0;
    conv_q.delete();
    sb.delete();
  endtask

  // Result is valid one edge after IR_en falls to zero at the end of a sweep.
  task automatic wait_result(input string tag);
    logic [2:0] prev;
    bit hit;
    exp_t x;
    hit  = 1'b0;
    prev = IR_en;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(posedge clk);
      #1;
      if (prev != 3'b000 && IR_en == 3'b000) hit = 1'b1;
      prev = IR_en;
    end
    if (!hit || sb.size() == 0) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk({tag, "_lft"},   int'(lft),   x.l);
      chk({tag, "_rht"},   int'(rht),   x.r);
      chk({tag, "_leds"},  int'(LEDs),  x.leds);
      chk({tag, "_lft_i"}, int'(lft_i), x.li);
      chk({tag, "_rht_i"}, int'(rht_i), x.ri);
      chk({tag, "_nconv"}, conv_q.size(), 6);
      for (int i = 0; i < conv_q.size() && i < 6; i++) chk({tag, "_chnnl"}, conv_q[i], i);
      conv_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int bad;
    bit found;
    n_run = 0; n_fail = 0; oh_bad = 0; integ_i = 0;
    set_ch(354, 354, 354, 354);

    do_reset();
    chk("rst_lft",   int'(lft), 0);
    chk("rst_rht",   int'(rht), 0);
    chk("rst_leds",  int'(LEDs), 0);
    chk("rst_ir_en", int'(IR_en), 0);
    chk("rst_start", int'(start_conv), 0);
    chk("rst_chnnl", int'(chnnl), 0);

    // 1: balanced readings
    push_exp();
    go = 1'b1;
    wait_result("t1");
    chk("t1_lft_abs", int'(lft), 512);

    // 2: outer-right sensor high
    do_reset();
    set_ch(712, 354, 354, 354);
    push_exp();
    go = 1'b1;
    wait_result("t2");
    chk("t2_rht_abs", int'(rht), 870);

    // 3: heavily weighted pair saturates the error and the motor commands
    do_reset();
    set_ch(354, 354, 4095, 0);
    push_exp();
    go = 1'b1;
    wait_result("t3");
    chk("t3_rht_abs", int'(rht), 1023);

    // 4: go drops in WAIT_L of pair 1; the late completion must be ignored
    do_reset();
    set_ch(712, 354, 354, 354);
    push_exp();
    go = 1'b1;
    wait_result("t4");
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(posedge clk);
      #1;
      if (start_conv && chnnl == 3'd3) found = 1'b1;
    end
    chk("t4_found_ch3", int'(found), 1);
    @(posedge clk);
    #1 go = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_ir_en", int'(IR_en), 0);
    chk("t4_lft",   int'(lft), 0);
    chk("t4_rht",   int'(rht), 0);
    chk("t4_start", int'(start_conv), 0);
    bad = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (start_conv || IR_en != 3'b000 || lft != 0 || rht != 0 || lft_i != 0) bad++;
    end
    chk("t4_idle_hold", bad, 0);

    // 5: async reset during SETTLE of pair 2, then restart with go still high
    do_reset();
    push_exp();
    go = 1'b1;
    wait_result("t5");
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(posedge clk);
      #1;
      if (IR_en == 3'b100) found = 1'b1;
    end
    chk("t5_found_p2", int'(found), 1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_lft",   int'(lft), 0);
    chk("t5_rht",   int'(rht), 0);
    chk("t5_leds",  int'(LEDs), 0);
    chk("t5_ir_en", int'(IR_en), 0);
    chk("t5_start", int'(start_conv), 0);
    chk("t5_chnnl", int'(chnnl), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    integ_i = 0;
    conv_q.delete();
    push_exp();
    @(posedge clk);
    #1;
    chk("t5_restart_ir", int'(IR_en), 1);
    wait_result("t5r");

    // 6: integrator builds over three continuous sweeps (KI=8 instance)
    do_reset();
    set_ch(712, 354, 354, 354);
    repeat (3) push_exp();
    go = 1'b1;
    wait_result("t6a");
    chk("t6a_rht_abs", int'(rht_i), 881);
    wait_result("t6b");
    chk("t6b_rht_abs", int'(rht_i), 892);
    wait_result("t6c");
    chk("t6c_rht_abs", int'(rht_i), 903);
    go = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    chk("ir_onehot", oh_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
